// File: rtl/uart_data_fifo_pkg.sv
// Shared UART FIFO constants: default geometry and derived pointer width.
package uart_data_fifo_pkg;

   localparam int unsigned UART_FIFO_WIDTH     = 8;
   localparam int unsigned UART_FIFO_DEPTH     = 16;
   localparam int unsigned UART_FIFO_COUNTER_W = 5;
   localparam int unsigned UART_FIFO_ERR_W     = 3;
   localparam int unsigned UART_FIFO_PTR_W     = $clog2(UART_FIFO_DEPTH);

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read, async clear.
// Also exposes a per-entry OR of the low ERR_W bits for the aggregate error flag.
module uart_fifo_ram
   import uart_data_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = UART_FIFO_WIDTH,
   parameter int unsigned DEPTH = UART_FIFO_DEPTH,
   parameter int unsigned ERR_W = UART_FIFO_ERR_W,
   parameter int unsigned PTR_W = UART_FIFO_PTR_W
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_we,
   input  logic [PTR_W-1:0] i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [PTR_W-1:0] i_raddr,
   output logic [WIDTH-1:0] o_rdata,
   output logic [DEPTH-1:0] o_err
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_comb begin
      o_err = '0;
      for (int unsigned i = 0; i < DEPTH; i++) o_err[i] = |r_mem[i][ERR_W-1:0];
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_data_fifo.sv
// First-word-fall-through UART data FIFO with edge-triggered pop, sticky
// overrun/underrun flags and an aggregate error flag over valid entries.
module uart_data_fifo
   import uart_data_fifo_pkg::*;
#(
   parameter int unsigned WIDTH   = UART_FIFO_WIDTH,
   parameter int unsigned DEPTH   = UART_FIFO_DEPTH,
   parameter int unsigned COUNT_W = UART_FIFO_COUNTER_W,
   parameter int unsigned ERR_W   = UART_FIFO_ERR_W
) (
   input  logic               clk,
   input  logic               wb_rst_i,
   input  logic [WIDTH-1:0]   data_in,
   input  logic               push,
   input  logic               pop,
   input  logic               fifo_reset,
   input  logic               reset_status,
   output logic [WIDTH-1:0]   data_out,
   output logic [COUNT_W-1:0] count,
   output logic               overrun,
   output logic               underrun,
   output logic               error_bit
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
   logic [COUNT_W-1:0] r_count;
   logic               r_pop_q, r_overrun, r_underrun;

   logic               w_pop_ev, w_full, w_empty;
   logic               w_do_push, w_do_pop, w_ovr_ev, w_udr_ev;
   logic [DEPTH-1:0]   w_ram_err;
   logic               w_err;

   assign w_pop_ev = pop & ~r_pop_q;
   assign w_full   = (r_count == COUNT_W'(DEPTH));
   assign w_empty  = (r_count == '0);

   // When full, a simultaneous pop frees the slot the write lands in.
   assign w_do_pop  = w_pop_ev & ~w_empty & ~fifo_reset;
   assign w_do_push = push & (~w_full | w_pop_ev) & ~fifo_reset;
   assign w_ovr_ev  = push & w_full & ~w_pop_ev & ~fifo_reset;
   assign w_udr_ev  = w_pop_ev & w_empty & ~fifo_reset;

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_pop_q    <= 1'b0;
         r_overrun  <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_pop_q <= pop;
         if (fifo_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
               2'b10:   r_count <= r_count + COUNT_W'(1);
               2'b01:   r_count <= r_count - COUNT_W'(1);
               default: r_count <= r_count;
            endcase
         end
         if (w_ovr_ev)          r_overrun  <= 1'b1;
         else if (reset_status) r_overrun  <= 1'b0;
         if (w_udr_ev)          r_underrun <= 1'b1;
         else if (reset_status) r_underrun <= 1'b0;
      end
   end

   uart_fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .ERR_W (ERR_W),
      .PTR_W (PTR_W)
   ) u_ram (
      .i_clk   (clk),
      .i_rst   (wb_rst_i),
      .i_we    (w_do_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (data_in),
      .i_raddr (r_rd_ptr),
      .o_rdata (data_out),
      .o_err   (w_ram_err)
   );

   // Only the r_count entries starting at the head contribute.
   always_comb begin
      w_err = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (COUNT_W'(i) < r_count) w_err = w_err | w_ram_err[r_rd_ptr + PTR_W'(i)];
      end
   end

   assign count     = r_count;
   assign overrun   = r_overrun;
   assign underrun  = r_underrun;
   assign error_bit = w_err;

endmodule

// File: tb/tb_uart_data_fifo.sv
// Directed bench for uart_data_fifo: an 8-bit instance checked against a
// scoreboard queue, plus an 11-bit instance for the error flag and flush.
module tb_uart_data_fifo;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [7:0]  a_din, a_dout;
   logic        a_push, a_pop, a_frst, a_rstat, a_ovr, a_udr, a_err;
   logic [4:0]  a_cnt;

   logic [10:0] b_din, b_dout;
   logic        b_push, b_pop, b_frst, b_rstat, b_ovr, b_udr, b_err;
   logic [4:0]  b_cnt;

   int tests  = 0;
   int failed = 0;

   logic [7:0] sb[$];

   uart_data_fifo dut8 (
      .clk (clk), .wb_rst_i (rst), .data_in (a_din), .push (a_push), .pop (a_pop),
      .fifo_reset (a_frst), .reset_status (a_rstat), .data_out (a_dout), .count (a_cnt),
      .overrun (a_ovr), .underrun (a_udr), .error_bit (a_err)
   );

   uart_data_fifo #(.WIDTH(11)) dut11 (
      .clk (clk), .wb_rst_i (rst), .data_in (b_din), .push (b_push), .pop (b_pop),
      .fifo_reset (b_frst), .reset_status (b_rstat), .data_out (b_dout), .count (b_cnt),
      .overrun (b_ovr), .underrun (b_udr), .error_bit (b_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic a_push_word(input logic [7:0] w);
      a_din  = w;
      a_push = 1'b1;
      tick();
      a_push = 1'b0;
      if (sb.size() < 16) sb.push_back(w);
   endtask

   // One pop edge on the 8-bit instance, head checked against the scoreboard.
   task automatic a_pop_pulse(input string tag);
      if (sb.size() == 0) begin
         tests++;
         failed++;
         $error("FAIL %s observed=pop expected=scoreboard_nonempty", tag);
      end else begin
         check(tag, 32'(a_dout), 32'(sb.pop_front()));
      end
      a_pop = 1'b1;
      tick();
      a_pop = 1'b0;
      tick();
   endtask

   task automatic b_push_word(input logic [10:0] w);
      b_din  = w;
      b_push = 1'b1;
      tick();
      b_push = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      {a_push, a_pop, a_frst, a_rstat} = '0;
      {b_push, b_pop, b_frst, b_rstat} = '0;
      a_din = '0;
      b_din = '0;
      repeat (2) tick();
      rst = 1'b0;
      tick();

      check("rst_count", 32'(a_cnt), 0);
      check("rst_dout",  32'(a_dout), 0);
      check("rst_ovr",   32'(a_ovr), 0);
      check("rst_udr",   32'(a_udr), 0);
      check("rst_err",   32'(a_err), 0);

      a_push_word(8'h41);
      a_push_word(8'h42);
      a_push_word(8'h43);
      check("three_count", 32'(a_cnt), 3);
      check("three_head",  32'(a_dout), 32'h41);
      a_pop_pulse("pop_41");
      check("pop1_head",  32'(a_dout), 32'(sb[0]));
      check("pop1_count", 32'(a_cnt), 2);

      a_pop = 1'b1;
      repeat (10) tick();
      a_pop = 1'b0;
      tick();
      void'(sb.pop_front());
      check("hold_head",  32'(a_dout), 32'h43);
      check("hold_count", 32'(a_cnt), 1);
      a_pop_pulse("pop_43");
      check("drain_count", 32'(a_cnt), 0);
      check("drain_udr",   32'(a_udr), 0);

      for (int i = 0; i < 17; i++) a_push_word(8'(8'h10 + i));
      check("full_count", 32'(a_cnt), 16);
      check("full_ovr",   32'(a_ovr), 1);
      a_rstat = 1'b1;
      tick();
      a_rstat = 1'b0;
      check("rstat_ovr",   32'(a_ovr), 0);
      check("rstat_count", 32'(a_cnt), 16);
      for (int i = 0; i < 16; i++) a_pop_pulse($sformatf("order_%0d", i));
      check("order_count", 32'(a_cnt), 0);

      a_pop = 1'b1;
      tick();
      a_pop = 1'b0;
      tick();
      check("empty_pop_udr",   32'(a_udr), 1);
      check("empty_pop_count", 32'(a_cnt), 0);
      a_rstat = 1'b1;
      tick();
      a_rstat = 1'b0;
      check("udr_cleared", 32'(a_udr), 0);
      a_din  = 8'h77;
      a_push = 1'b1;
      a_pop  = 1'b1;
      tick();
      a_push = 1'b0;
      a_pop  = 1'b0;
      tick();
      sb.push_back(8'h77);
      check("pp_empty_count", 32'(a_cnt), 1);
      check("pp_empty_udr",   32'(a_udr), 1);
      a_pop_pulse("pp_empty_head");

      for (int i = 0; i < 16; i++) a_push_word(8'(8'h80 + i));
      check("refill_count", 32'(a_cnt), 16);
      check("refill_head",  32'(a_dout), 32'h80);
      a_din  = 8'h99;
      a_push = 1'b1;
      a_pop  = 1'b1;
      tick();
      a_push = 1'b0;
      a_pop  = 1'b0;
      tick();
      void'(sb.pop_front());
      sb.push_back(8'h99);
      check("pp_full_count", 32'(a_cnt), 16);
      check("pp_full_ovr",   32'(a_ovr), 0);
      for (int i = 0; i < 16; i++) a_pop_pulse($sformatf("pp_full_drain_%0d", i));
      check("pp_full_end", 32'(a_cnt), 0);

      check("w11_rst_err", 32'(b_err), 0);
      b_push_word(11'h004);
      b_push_word(11'h100);
      check("w11_err2",  32'(b_err), 1);
      check("w11_count", 32'(b_cnt), 2);
      b_pop = 1'b1;
      tick();
      b_pop = 1'b0;
      tick();
      check("w11_head",     32'(b_dout), 32'h100);
      check("w11_err_pop",  32'(b_err), 0);
      b_push_word(11'h200);
      b_push_word(11'h001);
      b_push_word(11'h300);
      b_push_word(11'h0F8);
      check("w11_count5", 32'(b_cnt), 5);
      check("w11_err5",   32'(b_err), 1);
      b_frst = 1'b1;
      b_push = 1'b1;
      b_din  = 11'h007;
      tick();
      b_frst = 1'b0;
      b_push = 1'b0;
      check("w11_flush_count", 32'(b_cnt), 0);
      check("w11_flush_err",   32'(b_err), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
